// File: rtl/controlador_teclado.sv
// rtl/controlador_teclado.sv - 4x4 hex keypad scanner with press/release debounce
//
// Purpose:
//   Drives the keypad columns one-hot, samples the rows through a 2-flop
//   synchronizer, debounces the press and the release, and reports each
//   accepted key as a 4-bit code {row_idx, col_idx} with a 1-cycle strobe.
//
// Optional feature macro: TECLADO_REPETICION_EN
//   When defined, a held key re-strobes tecla_valida every REPEAT_CYCLES
//   cycles with tecla_bin unchanged. When undefined, each press yields
//   exactly one strobe and REPEAT_CYCLES has no effect.
//
// Ports:
//   clk               in   1  system clock, rising edge
//   rst               in   1  synchronous reset, active-high
//   filas_in          in   4  raw keypad rows, active-high, asynchronous
//   columnas_out      out  4  one-hot column drive, active-high
//   tecla_bin         out  4  code of the last accepted key
//   tecla_valida      out  1  1-cycle strobe per accepted key (or repeat)
//   tecla_presionada  out  1  high from accept until debounced release

module controlador_teclado #(
   parameter int SCAN_DIV        = 4,
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int REPEAT_CYCLES   = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] filas_in,
   output logic [3:0] columnas_out,
   output logic [3:0] tecla_bin,
   output logic       tecla_valida,
   output logic       tecla_presionada
);

   localparam int DW  = $clog2(SCAN_DIV);
   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {
      ESCANEO        = 2'd0,
      ANTIRREBOTE    = 2'd1,
      CAPTURA        = 2'd2,
      ESPERA_LIBERAR = 2'd3
   } estado_t;

   estado_t        estado_q;
   logic [3:0]     filas_m_q;
   logic [3:0]     filas_s_q;
   logic [1:0]     col_idx_q;
   logic [1:0]     fila_idx_q;
   logic [DW-1:0]  dwell_q;
   logic [DBW-1:0] deb_cnt_q;
   logic [DBW-1:0] lib_cnt_q;
   logic [3:0]     tecla_q;
   logic           valida_q;
   logic           presionada_q;

   logic [3:0]     fila_lat;
   logic [1:0]     col_idx_d;
   logic           coincide;
   logic           libre;
   logic [DBW-1:0] deb_cnt_inc;
   logic [DBW-1:0] lib_cnt_inc;

`ifdef TECLADO_REPETICION_EN
   localparam int RPW = $clog2(REPEAT_CYCLES + 1);
   logic [RPW-1:0] rep_cnt_q;
   logic [RPW-1:0] rep_cnt_inc;
`else
   // Parameter kept so both builds share one instantiation interface.
   logic parametro_unused;
   assign parametro_unused = (REPEAT_CYCLES != 0);
`endif

   // Row index of a one-hot row vector; only used when the vector is one-hot.
   function automatic logic [1:0] indice_fila(input logic [3:0] v);
      logic [1:0] r;
      case (v)
         4'b0001: r = 2'd0;
         4'b0010: r = 2'd1;
         4'b0100: r = 2'd2;
         4'b1000: r = 2'd3;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

   always_comb begin
      fila_lat    = 4'b0001 << fila_idx_q;
      col_idx_d   = col_idx_q + 2'd1;   // 2-bit wrap gives the 0001->...->1000->0001 rotation
      coincide    = (filas_s_q == fila_lat);
      libre       = (filas_s_q == 4'b0000);
      deb_cnt_inc = (deb_cnt_q < DBW'(DEBOUNCE_CYCLES)) ? deb_cnt_q + DBW'(1) : deb_cnt_q;
      lib_cnt_inc = (lib_cnt_q < DBW'(DEBOUNCE_CYCLES)) ? lib_cnt_q + DBW'(1) : lib_cnt_q;
`ifdef TECLADO_REPETICION_EN
      rep_cnt_inc = (rep_cnt_q < RPW'(REPEAT_CYCLES)) ? rep_cnt_q + RPW'(1) : rep_cnt_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q     <= ESCANEO;
         filas_m_q    <= 4'b0000;
         filas_s_q    <= 4'b0000;
         col_idx_q    <= 2'd0;
         fila_idx_q   <= 2'd0;
         dwell_q      <= '0;
         deb_cnt_q    <= '0;
         lib_cnt_q    <= '0;
         tecla_q      <= 4'h0;
         valida_q     <= 1'b0;
         presionada_q <= 1'b0;
`ifdef TECLADO_REPETICION_EN
         rep_cnt_q    <= '0;
`endif
      end else begin
         filas_m_q <= filas_in;
         filas_s_q <= filas_m_q;
         valida_q  <= 1'b0;

         case (estado_q)
            ESCANEO: begin
               // The last dwell cycle sees rows that settled through the
               // synchronizer for the column driven since dwell 0.
               if (dwell_q == DW'(SCAN_DIV - 1)) begin
                  dwell_q <= '0;
                  if ($onehot(filas_s_q)) begin
                     fila_idx_q <= indice_fila(filas_s_q);
                     deb_cnt_q  <= '0;
                     estado_q   <= ANTIRREBOTE;
                  end else begin
                     col_idx_q <= col_idx_d;
                  end
               end else begin
                  dwell_q <= dwell_q + DW'(1);
               end
            end

            ANTIRREBOTE: begin
               if (coincide) begin
                  if (deb_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
                     // Outputs are registered, so they are loaded here and
                     // become visible during the CAPTURA cycle itself.
                     tecla_q      <= {fila_idx_q, col_idx_q};
                     valida_q     <= 1'b1;
                     presionada_q <= 1'b1;
                     estado_q     <= CAPTURA;
                  end else begin
                     deb_cnt_q <= deb_cnt_inc;
                  end
               end else begin
                  col_idx_q <= col_idx_d;
                  dwell_q   <= '0;
                  estado_q  <= ESCANEO;
               end
            end

            CAPTURA: begin
               lib_cnt_q <= '0;
               estado_q  <= ESPERA_LIBERAR;
`ifdef TECLADO_REPETICION_EN
               // The CAPTURA cycle counts as the first held cycle so the
               // first repeat lands exactly REPEAT_CYCLES after the accept.
               rep_cnt_q <= coincide ? RPW'(1) : '0;
`endif
            end

            ESPERA_LIBERAR: begin
               if (libre) begin
                  if (lib_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
                     lib_cnt_q    <= '0;
                     presionada_q <= 1'b0;
                     col_idx_q    <= col_idx_d;
                     dwell_q      <= '0;
                     estado_q     <= ESCANEO;
                  end else begin
                     lib_cnt_q <= lib_cnt_inc;
                  end
               end else begin
                  // Any row activity, even a different key, restarts the release.
                  lib_cnt_q <= '0;
               end
`ifdef TECLADO_REPETICION_EN
               if (coincide) begin
                  if (rep_cnt_q == RPW'(REPEAT_CYCLES - 1)) begin
                     valida_q  <= 1'b1;
                     rep_cnt_q <= '0;
                  end else begin
                     rep_cnt_q <= rep_cnt_inc;
                  end
               end else begin
                  rep_cnt_q <= '0;
               end
`endif
            end

            default: estado_q <= ESCANEO;
         endcase
      end
   end

   assign columnas_out     = 4'b0001 << col_idx_q;
   assign tecla_bin        = tecla_q;
   assign tecla_valida     = valida_q;
   assign tecla_presionada = presionada_q;

endmodule

// File: tb/tb_controlador_teclado.sv
// tb/tb_controlador_teclado.sv - scoreboard bench for controlador_teclado

module tb_controlador_teclado;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 8;
   localparam int REP      = 50;
`ifdef TECLADO_REPETICION_EN
   localparam int HOLD_T2   = 40;
   localparam int HOLD_RAND = 40;
`else
   localparam int HOLD_T2   = 200;
   localparam int HOLD_RAND = 150;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] filas_in;
   logic [3:0] columnas_out;
   logic [3:0] tecla_bin;
   logic       tecla_valida;
   logic       tecla_presionada;

   always #5 clk = ~clk;

   controlador_teclado #(
      .SCAN_DIV        (SCAN_DIV),
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_CYCLES   (REP)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .filas_in         (filas_in),
      .columnas_out     (columnas_out),
      .tecla_bin        (tecla_bin),
      .tecla_valida     (tecla_valida),
      .tecla_presionada (tecla_presionada)
   );

   // Keypad model: a pressed key closes its row only while its column is driven.
   logic [15:0] pulsadas;
   logic        rebote_off;

   always_comb begin
      filas_in = 4'b0000;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pulsadas[r*4+c] && columnas_out[c] && !rebote_off)
               filas_in[r] = 1'b1;
   end

   int         n_checks = 0;
   int         n_pass   = 0;
   int         cyc      = 0;
   logic [3:0] esperado_q[$];
   int         strobe_cyc[$];
   logic       valida_prev = 1'b0;

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every strobe must match the oldest expected key.
   always @(negedge clk) begin
      if (rst) begin
         valida_prev <= 1'b0;
      end else begin
         if (tecla_valida) begin
            strobe_cyc.push_back(cyc);
            chk(esperado_q.size() != 0, "strobe_esperado", esperado_q.size(), 1);
            if (esperado_q.size() != 0) begin
               chk(tecla_bin == esperado_q[0], "tecla_bin", tecla_bin, esperado_q[0]);
               esperado_q.delete(0);
            end
            chk(tecla_presionada == 1'b1, "presionada_en_strobe", tecla_presionada, 1);
            chk(!valida_prev, "strobe_doble", valida_prev, 0);
         end
         valida_prev <= tecla_valida;
      end
   end

   task automatic ciclos(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulsar(input int r, input int c);
      pulsadas[r*4+c] = 1'b1;
   endtask

   task automatic soltar(input int r, input int c);
      pulsadas[r*4+c] = 1'b0;
   endtask

   task automatic esperar_strobe(input int pendientes, input string name);
      int n = 0;
      while (esperado_q.size() > pendientes && n < 120) begin
         ciclos(1);
         n++;
      end
      chk(esperado_q.size() <= pendientes, name, esperado_q.size(), pendientes);
   endtask

   task automatic esperar_col(input logic [3:0] col, input int limite, input string name);
      int n = 0;
      while (columnas_out != col && n < limite) begin
         ciclos(1);
         n++;
      end
      chk(columnas_out == col, name, columnas_out, col);
   endtask

   initial begin
      logic [3:0] exp_col;
      logic [3:0] col_ini;
      bit         visto;
      int         n;
      rst        = 1'b1;
      pulsadas   = '0;
      rebote_off = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk(columnas_out == 4'b0001, "reset_columnas", columnas_out, 1);
      chk(tecla_bin == 4'h0, "reset_tecla_bin", tecla_bin, 0);
      chk(tecla_valida == 1'b0, "reset_valida", tecla_valida, 0);
      chk(tecla_presionada == 1'b0, "reset_presionada", tecla_presionada, 0);
      rst = 1'b0;

      // 1: idle rotation, one column per SCAN_DIV cycles starting at 0001
      for (int k = 0; k < 40; k++) begin
         exp_col = 4'b0001 << ((k / SCAN_DIV) % 4);
         chk(columnas_out == exp_col, "rotacion_reposo", columnas_out, exp_col);
         ciclos(1);
      end
      chk(tecla_bin == 4'h0, "reposo_tecla_bin", tecla_bin, 0);

      // 2: (row1,col2) -> 4'h6, release debounced 8 cycles after filas_s clears
      pulsar(1, 2);
      esperado_q.push_back(4'h6);
      esperar_strobe(0, "t2_timeout");
      ciclos(HOLD_T2);
      chk(tecla_presionada == 1'b1, "t2_presionada", tecla_presionada, 1);
      chk(columnas_out == 4'b0100, "t2_columna_congelada", columnas_out, 4'b0100);
      soltar(1, 2);
      n = 0;
      while (tecla_presionada && n < 30) begin
         ciclos(1);
         n++;
      end
      chk(n == DEB + 2, "t2_ciclos_liberacion", n, DEB + 2);
      col_ini = columnas_out;
      visto   = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (columnas_out != col_ini) visto = 1'b1;
         ciclos(1);
      end
      chk(visto, "t2_escaneo_reanudado", visto, 1);

      // 3: (row0,col0) bouncing every 3 cycles, then stable -> single 4'h0
      pulsar(0, 0);
      for (int k = 0; k < 7; k++) begin
         rebote_off = ~rebote_off;
         ciclos(3);
      end
      rebote_off = 1'b0;
      esperado_q.push_back(4'h0);
      esperar_strobe(0, "t3_timeout");
      ciclos(30);
      soltar(0, 0);
      ciclos(25);

      // 4: two keys in one column are ignored; releasing one yields 4'h1
      pulsar(0, 1);
      pulsar(1, 1);
      visto = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (columnas_out == 4'b0100) visto = 1'b1;
         ciclos(1);
      end
      chk(visto, "t4_sigue_rotando", visto, 1);
      chk(tecla_presionada == 1'b0, "t4_sin_presion", tecla_presionada, 0);
      soltar(1, 1);
      esperado_q.push_back(4'h1);
      esperar_strobe(0, "t4_timeout");
      ciclos(30);
      soltar(0, 1);
      ciclos(25);

      // 5: reset during ANTIRREBOTE aborts without a strobe
      esperar_col(4'b0010, 20, "t5_col1");
      pulsar(2, 3);
      esperar_col(4'b0100, 10, "t5_col2");
      esperar_col(4'b1000, 10, "t5_col3");
      ciclos(6);
      chk(columnas_out == 4'b1000, "t5_columna_congelada", columnas_out, 4'b1000);
      chk(tecla_bin == 4'h1, "t5_tecla_previa", tecla_bin, 1);
      rst = 1'b1;
      soltar(2, 3);
      ciclos(1);
      chk(columnas_out == 4'b0001, "t5_reset_columnas", columnas_out, 1);
      chk(tecla_bin == 4'h0, "t5_reset_tecla_bin", tecla_bin, 0);
      chk(tecla_valida == 1'b0, "t5_reset_valida", tecla_valida, 0);
      chk(tecla_presionada == 1'b0, "t5_reset_presionada", tecla_presionada, 0);
      rst = 1'b0;
      ciclos(40);

`ifdef TECLADO_REPETICION_EN
      // 6: held (row3,col3) repeats every REP cycles, nothing after release
      strobe_cyc.delete();
      pulsar(3, 3);
      repeat (4) esperado_q.push_back(4'hF);
      esperar_strobe(3, "t6_timeout");
      ciclos(180);
      soltar(3, 3);
      ciclos(60);
      chk(esperado_q.size() == 0, "t6_repeticiones", esperado_q.size(), 0);
      chk(strobe_cyc.size() == 4, "t6_num_strobes", strobe_cyc.size(), 4);
      if (strobe_cyc.size() == 4)
         for (int i = 0; i < 3; i++)
            chk(strobe_cyc[i+1] - strobe_cyc[i] == REP, "t6_periodo",
                strobe_cyc[i+1] - strobe_cyc[i], REP);
`endif

      // Random presses with random bounce prefixes and hold times
      for (int it = 0; it < 12; it++) begin
         int r;
         int c;
         int nb;
         r  = $urandom_range(0, 3);
         c  = $urandom_range(0, 3);
         nb = $urandom_range(0, 4);
         pulsar(r, c);
         for (int j = 0; j < nb * 2; j++) begin
            rebote_off = ~rebote_off;
            ciclos(3);
         end
         rebote_off = 1'b0;
         esperado_q.push_back(4'(r * 4 + c));
         esperar_strobe(0, "rand_timeout");
         ciclos($urandom_range(5, HOLD_RAND));
         soltar(r, c);
         ciclos($urandom_range(15, 30));
      end

      ciclos(20);
      chk(esperado_q.size() == 0, "cola_vacia", esperado_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
